// File: rtl/cmd_pkg.sv
// cmd_pkg: command word bit map and encoder state encoding, shared by the
// command encoder and the actuator command decoder.
package cmd_pkg;

   // Command word bit positions
   localparam int BIT_ON     = 0;
   localparam int BIT_OFF    = 1;
   localparam int BIT_INC    = 2;
   localparam int BIT_DEC    = 3;
   localparam int BIT_RX     = 4;
   localparam int BIT_TX     = 5;
   localparam int BIT_VALID  = 6;
   localparam int AMOUNT_LSB = 7;

   // Encoder states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_GAP   = 2'd2
   } enc_state_t;

   // Width of the shared pulse/gap down-counter: clog2(max(pulse, gap, 2))
   function automatic int cnt_width(input int pulse, input int gap);
      int m;
      m = (pulse > gap) ? pulse : gap;
      if (m < 2) m = 2;
      return $clog2(m);
   endfunction

endpackage

// File: rtl/cmd_word_pack.sv
// cmd_word_pack: combinational legality check and command word packing.
// The packed word always carries the valid bit; the caller decides when to
// present it. Reused by the decoder self-test.
module cmd_word_pack
   import cmd_pkg::*;
#(
   parameter int AMOUNT_WIDTH = 8,
   parameter int DATA_WIDTH   = 15
)(
   input  logic                    i_on,
   input  logic                    i_off,
   input  logic                    i_inc,
   input  logic                    i_dec,
   input  logic                    i_rx,
   input  logic                    i_tx,
   input  logic [AMOUNT_WIDTH-1:0] i_amount,
   output logic                    o_legal,
   output logic [DATA_WIDTH-1:0]   o_word
);

   // Legality: opposing action pairs may not be requested together
   always_comb begin
      o_legal = ~(i_on & i_off) & ~(i_inc & i_dec);
   end

   // Pack flags, valid bit and amount into the command word layout
   always_comb begin
      o_word                              = '0;
      o_word[BIT_ON]                      = i_on;
      o_word[BIT_OFF]                     = i_off;
      o_word[BIT_INC]                     = i_inc;
      o_word[BIT_DEC]                     = i_dec;
      o_word[BIT_RX]                      = i_rx;
      o_word[BIT_TX]                      = i_tx;
      o_word[BIT_VALID]                   = 1'b1;
      o_word[AMOUNT_LSB +: AMOUNT_WIDTH]  = i_amount;
   end

endmodule

// File: rtl/cmd_word_encoder.sv
// cmd_word_encoder: accepts one command at a time over valid/ready, rejects
// conflicting requests, and drives the packed word for PULSE_CYCLES cycles
// followed by GAP_CYCLES all-zero cycles.
// Optional feature: define CMD_ENC_REJECT_CNT_EN to add the saturating
// rej_count output.
module cmd_word_encoder
   import cmd_pkg::*;
#(
   parameter int DATA_WIDTH   = 15,
   parameter int AMOUNT_WIDTH = 8,
   parameter int PULSE_CYCLES = 1,
   parameter int GAP_CYCLES   = 1
)(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_on,
   input  logic                    cmd_off,
   input  logic                    cmd_inc,
   input  logic                    cmd_dec,
   input  logic                    cmd_send,
   input  logic                    cmd_receive,
   input  logic [AMOUNT_WIDTH-1:0] cmd_amount,
   output logic [DATA_WIDTH-1:0]   tx_data,
   output logic                    busy,
   output logic                    err_illegal
`ifdef CMD_ENC_REJECT_CNT_EN
   ,
   output logic [7:0]              rej_count
`endif
);

   localparam int CW = cnt_width(PULSE_CYCLES, GAP_CYCLES);
   localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LD   = (GAP_CYCLES > 0) ? CW'(GAP_CYCLES - 1) : '0;
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   enc_state_t            r_state;
   logic [CW-1:0]         r_cnt;
   logic [DATA_WIDTH-1:0] r_tx_data;
   logic                  r_busy;
   logic                  r_err;

   enc_state_t            w_state_nxt;
   logic [CW-1:0]         w_cnt_nxt;
   logic [DATA_WIDTH-1:0] w_tx_nxt;
   logic                  w_err_nxt;
   logic                  w_legal;
   logic [DATA_WIDTH-1:0] w_word;

   cmd_word_pack #(
      .AMOUNT_WIDTH (AMOUNT_WIDTH),
      .DATA_WIDTH   (DATA_WIDTH)
   ) u_pack (
      .i_on     (cmd_on),
      .i_off    (cmd_off),
      .i_inc    (cmd_inc),
      .i_dec    (cmd_dec),
      .i_rx     (cmd_receive),
      .i_tx     (cmd_send),
      .i_amount (cmd_amount),
      .o_legal  (w_legal),
      .o_word   (w_word)
   );

   // Next-state, counter and output-word decode; one counter serves both
   // the pulse and the gap phase
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_tx_nxt    = r_tx_data;
      w_err_nxt   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_tx_nxt = '0;
            if (cmd_valid) begin
               if (w_legal) begin
                  w_state_nxt = ST_DRIVE;
                  w_cnt_nxt   = PULSE_LD;
                  w_tx_nxt    = w_word;
               end else begin
                  w_err_nxt = 1'b1;
               end
            end
         end
         ST_DRIVE: begin
            if (r_cnt == '0) begin
               w_tx_nxt = '0;
               if (GAP_CYCLES == 0) begin
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_state_nxt = ST_GAP;
                  w_cnt_nxt   = GAP_LD;
               end
            end else begin
               w_cnt_nxt = r_cnt - CNT_ONE;
            end
         end
         ST_GAP: begin
            w_tx_nxt = '0;
            if (r_cnt == '0) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_cnt_nxt = r_cnt - CNT_ONE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_tx_nxt    = '0;
         end
      endcase
   end

   // State and registered outputs; busy tracks the next state so it is
   // registered yet aligned with the state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_cnt     <= '0;
         r_tx_data <= '0;
         r_busy    <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_tx_data <= w_tx_nxt;
         r_busy    <= (w_state_nxt != ST_IDLE);
         r_err     <= w_err_nxt;
      end
   end

   assign cmd_ready   = (r_state == ST_IDLE);
   assign tx_data     = r_tx_data;
   assign busy        = r_busy;
   assign err_illegal = r_err;

`ifdef CMD_ENC_REJECT_CNT_EN
   logic [7:0] r_rej_cnt;

   // Saturating count of rejected commands, cleared only by reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rej_cnt <= 8'd0;
      end else if (w_err_nxt && (r_rej_cnt != 8'hFF)) begin
         r_rej_cnt <= r_rej_cnt + 8'd1;
      end
   end

   assign rej_count = r_rej_cnt;
`endif

endmodule

// File: tb/tb_cmd_word_encoder.sv
// Bench for cmd_word_encoder: two instances (default timing and
// PULSE_CYCLES=2/GAP_CYCLES=3) share one stimulus stream. A timeline model
// (handshake edge + word per instance) predicts every output each cycle;
// directed literal checks pin the model.
module tb_cmd_word_encoder;

   localparam int AW = 8;
   localparam int DW = 15;
   localparam int P0 = 1, G0 = 1, P1 = 2, G1 = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic          cmd_valid = 1'b0;
   logic          cmd_on = 1'b0, cmd_off = 1'b0, cmd_inc = 1'b0, cmd_dec = 1'b0;
   logic          cmd_send = 1'b0, cmd_receive = 1'b0;
   logic [AW-1:0] cmd_amount = '0;

   logic [1:0]         rdy, bsy, err;
   logic [1:0][DW-1:0] txd;
`ifdef CMD_ENC_REJECT_CNT_EN
   logic [1:0][7:0]    rejc;
`endif

   cmd_word_encoder #(.DATA_WIDTH(DW), .AMOUNT_WIDTH(AW), .PULSE_CYCLES(P0), .GAP_CYCLES(G0)) u_dut0 (
      .clk(clk), .rst_n(rst_n),
`ifdef CMD_ENC_REJECT_CNT_EN
      .rej_count(rejc[0]),
`endif
      .cmd_valid(cmd_valid), .cmd_ready(rdy[0]),
      .cmd_on(cmd_on), .cmd_off(cmd_off), .cmd_inc(cmd_inc), .cmd_dec(cmd_dec),
      .cmd_send(cmd_send), .cmd_receive(cmd_receive), .cmd_amount(cmd_amount),
      .tx_data(txd[0]), .busy(bsy[0]), .err_illegal(err[0])
   );

   cmd_word_encoder #(.DATA_WIDTH(DW), .AMOUNT_WIDTH(AW), .PULSE_CYCLES(P1), .GAP_CYCLES(G1)) u_dut1 (
      .clk(clk), .rst_n(rst_n),
`ifdef CMD_ENC_REJECT_CNT_EN
      .rej_count(rejc[1]),
`endif
      .cmd_valid(cmd_valid), .cmd_ready(rdy[1]),
      .cmd_on(cmd_on), .cmd_off(cmd_off), .cmd_inc(cmd_inc), .cmd_dec(cmd_dec),
      .cmd_send(cmd_send), .cmd_receive(cmd_receive), .cmd_amount(cmd_amount),
      .tx_data(txd[1]), .busy(bsy[1]), .err_illegal(err[1])
   );

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // ecnt counts clock edges; hs[d] is the edge of the last accepted command,
   // rj[d] the edge of the last rejection.
   int pp[2] = '{P0, P1};
   int gg[2] = '{G0, G1};
   longint ecnt = 0;
   longint hs[2] = '{-1000, -1000};
   longint rj[2] = '{-1000, -1000};
   logic [DW-1:0] mword[2];
   int mrej[2] = '{0, 0};

   function automatic bit m_ready(input int d, input longint e);
      return e >= hs[d] + pp[d] + gg[d];
   endfunction

   function automatic logic [DW-1:0] ref_word();
      return {cmd_amount, 1'b1, cmd_send, cmd_receive, cmd_dec, cmd_inc, cmd_off, cmd_on};
   endfunction

   function automatic bit ref_legal();
      return !(cmd_on && cmd_off) && !(cmd_inc && cmd_dec);
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int d = 0; d < 2; d++) begin
            hs[d]   <= -1000;
            rj[d]   <= -1000;
            mrej[d] <= 0;
         end
      end else begin
         for (int d = 0; d < 2; d++) begin
            if (cmd_valid && m_ready(d, ecnt)) begin
               if (ref_legal()) begin
                  hs[d]    <= ecnt + 1;
                  mword[d] <= ref_word();
               end else begin
                  rj[d] <= ecnt + 1;
                  if (mrej[d] < 255) mrej[d] <= mrej[d] + 1;
               end
            end
         end
         ecnt <= ecnt + 1;
      end
   end

   // Per-cycle comparison of every output against the model
   always @(negedge clk) begin
      if (chk_en) begin
         for (int d = 0; d < 2; d++) begin
            logic [DW-1:0] etx;
            etx = (ecnt >= hs[d] && ecnt <= hs[d] + pp[d] - 1) ? mword[d] : '0;
            chk($sformatf("tx_data[%0d]", d), txd[d], etx);
            chk($sformatf("cmd_ready[%0d]", d), rdy[d], m_ready(d, ecnt));
            chk($sformatf("busy[%0d]", d), bsy[d], !m_ready(d, ecnt));
            chk($sformatf("err_illegal[%0d]", d), err[d], (rj[d] == ecnt));
`ifdef CMD_ENC_REJECT_CNT_EN
            chk($sformatf("rej_count[%0d]", d), rejc[d], mrej[d]);
`endif
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic set_cmd(input bit on, input bit off, input bit inc, input bit dec,
                          input bit rx, input bit tx, input logic [AW-1:0] amt);
      cmd_on = on; cmd_off = off; cmd_inc = inc; cmd_dec = dec;
      cmd_receive = rx; cmd_send = tx; cmd_amount = amt;
   endtask

   // Present one command for one cycle; returns at the negedge after the edge
   task automatic issue(input bit on, input bit off, input bit inc, input bit dec,
                        input bit rx, input bit tx, input logic [AW-1:0] amt);
      set_cmd(on, off, inc, dec, rx, tx, amt);
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      logic [11:0] pat;
      repeat (3) @(negedge clk);
      rst_n  = 1'b1;
      chk_en = 1'b1;
      chk("reset_ready", rdy, 2'b11);
      chk("reset_tx0", txd[0], 0);
      chk("reset_busy", bsy, 2'b00);
      chk("reset_err", err, 2'b00);

      @(negedge clk);
      issue(1, 0, 0, 0, 0, 0, 8'h05);
      chk("on_amt5_word", txd[0], 15'h02C1);
      chk("on_amt5_ready", rdy[0], 1'b0);
      @(negedge clk);
      chk("on_amt5_gap", txd[0], 0);
      chk("on_amt5_gap_ready", rdy[0], 1'b0);
      @(negedge clk);
      chk("on_amt5_ready_back", rdy[0], 1'b1);
      idle(8);

      issue(0, 0, 1, 0, 0, 1, 8'h10);
      chk("inc_send_word", txd[0], 15'h0864);
      idle(8);

      issue(0, 0, 0, 1, 1, 0, 8'hFF);
      chk("dec_rx_word", txd[0], 15'h7FD8);
      idle(8);

      issue(1, 1, 0, 0, 0, 0, 8'h22);
      chk("illegal_err", err[0], 1'b1);
      chk("illegal_tx", txd[0], 0);
      chk("illegal_ready", rdy[0], 1'b1);
`ifdef CMD_ENC_REJECT_CNT_EN
      chk("illegal_rej1", rejc[0], 8'd1);
`endif
      @(negedge clk);
      chk("illegal_err_drop", err[0], 1'b0);

      // 300 back-to-back rejections
      set_cmd(1, 1, 1, 1, 0, 0, 8'h01);
      cmd_valid = 1'b1;
      repeat (300) @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk);
`ifdef CMD_ENC_REJECT_CNT_EN
      chk("rej_saturate0", rejc[0], 8'd255);
      chk("rej_saturate1", rejc[1], 8'd255);
`endif
      idle(8);

      // Held valid: slow instance accepts every PULSE+GAP+1 = 6 cycles
      set_cmd(1, 0, 0, 0, 0, 0, 8'h33);
      cmd_valid = 1'b1;
      @(negedge clk);
      pat = '0;
      for (int i = 0; i < 12; i++) begin
         pat = {pat[10:0], (txd[1] != '0)};
         @(negedge clk);
      end
      cmd_valid = 1'b0;
      chk("held_pattern", pat, 12'b110000110000);
      idle(10);

      // Reset during the second DRIVE cycle of the slow instance
      issue(0, 0, 1, 0, 1, 0, 8'h0A);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midreset_tx1", txd[1], 0);
      chk("midreset_busy1", bsy[1], 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      chk("postreset_ready", rdy, 2'b11);
      issue(1, 0, 0, 0, 0, 0, 8'h05);
      chk("postreset_word0", txd[0], 15'h02C1);
      chk("postreset_word1", txd[1], 15'h02C1);
      idle(8);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         cmd_valid   = ($urandom_range(0, 3) != 0);
         cmd_on      = $urandom_range(0, 2) == 0;
         cmd_off     = $urandom_range(0, 2) == 0;
         cmd_inc     = $urandom_range(0, 2) == 0;
         cmd_dec     = $urandom_range(0, 2) == 0;
         cmd_send    = $urandom_range(0, 1) == 1;
         cmd_receive = $urandom_range(0, 1) == 1;
         cmd_amount  = AW'($urandom);
         @(negedge clk);
      end
      cmd_valid = 1'b0;
      idle(10);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/cmd_word_encoder.md
# cmd_word_encoder

Transmit-side counterpart of the actuator command decoder. Accepts one command at a time from the control logic (PS-side register interface or sequencer) over a valid/ready handshake, rejects conflicting requests, and packs the command flags plus amount into the DATA_WIDTH-bit command word. It drives the word onto the command bus with the valid bit set for a fixed number of cycles, then holds an all-zero inter-command gap so the decoder sees clean, separated commands.

## Interface
- DATA_WIDTH, 15: command word width; must equal AMOUNT_WIDTH + 7.
- AMOUNT_WIDTH, 8: amount field width.
- PULSE_CYCLES, 1: cycles the word is driven with the valid bit set; ≥1.
- GAP_CYCLES, 1: all-zero cycles after each pulse; ≥0.

- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command request present.
- cmd_ready  out  1  encoder can accept a command.
- cmd_on, cmd_off, cmd_inc, cmd_dec  in  1 each  requested actions.
- cmd_send, cmd_receive  in  1 each  transfer direction flags.
- cmd_amount  in  AMOUNT_WIDTH  amount value.
- tx_data  out  DATA_WIDTH  registered command word to the decoder.
- busy  out  1  high whenever state ≠ IDLE.
- err_illegal  out  1  one-cycle pulse on a rejected command.
- rej_count  out  8  rejected-command count (only with CMD_ENC_REJECT_CNT_EN).

## Operation
- Word layout: bit0 on, bit1 off, bit2 increase, bit3 decrease, bit4 receive, bit5 send, bit6 valid, bits[DATA_WIDTH-1:7] amount.
- Legal command: not (on & off) and not (inc & dec). Commands with no action flags set are legal; they carry amount only.
- States: IDLE, DRIVE, GAP.
- IDLE: cmd_ready=1, tx_data=0. On cmd_valid & cmd_ready:
  - Legal: latch the packed word with bit6=1, load the counter with PULSE_CYCLES-1, go to DRIVE.
  - Illegal: stay in IDLE, pulse err_illegal, leave tx_data at 0.
- DRIVE: tx_data holds the packed word, cmd_ready=0. When the counter reaches 0: if GAP_CYCLES=0 go to IDLE with tx_data=0, otherwise load GAP_CYCLES-1 and go to GAP with tx_data=0.
- GAP: tx_data=0, cmd_ready=0. When the counter reaches 0, go to IDLE.
- Inputs are sampled only at the handshake edge. Changes during DRIVE or GAP have no effect.
- Counter width: $clog2 of max(PULSE_CYCLES, GAP_CYCLES, 2).
- Reset values: state IDLE, tx_data 0, busy 0, err_illegal 0, rej_count 0. cmd_ready is 1 once rst_n deasserts.
- Reset asserted mid-DRIVE or mid-GAP: outputs go to reset values immediately (asynchronous); the in-flight command is dropped and not replayed.

## Timing
- Handshake at edge k:
  - tx_data shows the word from cycle k+1 through k+PULSE_CYCLES.
  - Zeros for the next GAP_CYCLES cycles.
  - cmd_ready returns high in cycle k+PULSE_CYCLES+GAP_CYCLES+1.
- Minimum command period: PULSE_CYCLES+GAP_CYCLES+1 cycles (the +1 is the IDLE accept cycle).
- err_illegal is high for exactly cycle k+1 after a rejected handshake at edge k. Back-to-back illegal commands pulse on consecutive cycles.
- All outputs are registered except cmd_ready, which is decoded from the state register.

## Configuration
- CMD_ENC_REJECT_CNT_EN defined: the rej_count port exists. It increments on each rejection and saturates at 255; it is cleared only by reset.
- Not defined: the port and counter are absent. err_illegal behaviour is unchanged.

## Structure
- Shared package cmd_pkg, shared with the decoder:
  - bit-index constants BIT_ON=0, BIT_OFF=1, BIT_INC=2, BIT_DEC=3, BIT_RX=4, BIT_TX=5, BIT_VALID=6, AMOUNT_LSB=7;
  - the encoder state enum.
- One sub-module, cmd_word_pack: combinational legality check plus word packing, reusable by the decoder's self-test.

## Test plan
- Defaults; cmd_on=1, cmd_amount=8'h05 -> tx_data=15'h02C1 for 1 cycle, then 0 for 1 cycle; cmd_ready low for 2 cycles.
- cmd_inc=1, cmd_send=1, cmd_amount=8'h10 -> tx_data=15'h0864.
- cmd_dec=1, cmd_receive=1, cmd_amount=8'hFF -> tx_data=15'h7FD8.
- cmd_on=1, cmd_off=1 -> tx_data stays 0; err_illegal high 1 cycle; cmd_ready stays 1; rej_count=1 (with macro). Repeat 300 times -> rej_count=255.
- PULSE_CYCLES=2, GAP_CYCLES=3, cmd_valid held with two commands -> each word held 2 cycles, 3 zero cycles between; second accept 6 cycles after the first.
- rst_n low during the second DRIVE cycle -> tx_data=0 in the same cycle, busy=0; after release cmd_ready=1 and the next command is sent normally.
